// File: rtl/mpeg_bit_window_pkg.sv
// mpeg_pkg: constants, the state encoding and a helper function shared by the
// MPEG bit window and the VLC decoders that sit behind it.
// No ports. Contents:
//   WORD_W / WIN_W / SHIFT_W  word, peek window and shift-amount widths
//   ST_STREAM / ST_DRAIN / ST_DONE  state encoding
//   VLC_ERROR                 error code shared with the VLC decoders
//   sat_win_bits()            number of valid window bits (count capped at WIN_W)
package mpeg_pkg;
  localparam int WORD_W  = 32;
  localparam int WIN_W   = 20;
  localparam int SHIFT_W = 5;
  localparam int BUF_W   = 64;
  localparam int CNT_W   = 7;

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int VLC_ERROR = 17;

  typedef enum logic [1:0] {
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_DONE   = ST_DONE
  } state_t;

  // Valid window bits: the buffer count, capped at the window width.
  function automatic logic [SHIFT_W-1:0] sat_win_bits(input logic [CNT_W-1:0] cnt);
    if (cnt >= 7'd20) begin
      return 5'd20;
    end else begin
      return cnt[SHIFT_W-1:0];
    end
  endfunction
endpackage

// File: rtl/mpeg_bit_window_if.sv
// mpeg_bit_window_if: stream input handshake plus decoder-side window/shift
// signals of the MPEG bit window.
//   in_data/in_valid/in_last/in_ready   32-bit stream word handshake
//   win/win_valid/win_bits              20-bit peek window, earliest bit at win[19]
//   shift_req/shift_amt/align_req       consume request from the decoder
//   err/eos                             sticky illegal-shift flag, end of stream
//   bits_consumed/words_in              statistics, only with MPEG_BITWIN_STATS_EN
// Modports: master = stream source + decoder side, slave = the bit window.
interface mpeg_bit_window_if;
  import mpeg_pkg::*;

  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [WIN_W-1:0]   win;
  logic               win_valid;
  logic [SHIFT_W-1:0] win_bits;
  logic               shift_req;
  logic [SHIFT_W-1:0] shift_amt;
  logic               align_req;
  logic               err;
  logic               eos;
`ifdef MPEG_BITWIN_STATS_EN
  logic [31:0]        bits_consumed;
  logic [15:0]        words_in;
`endif

  modport master (
    output in_data, in_valid, in_last, shift_req, shift_amt, align_req,
    input  in_ready, win, win_valid, win_bits, err, eos
`ifdef MPEG_BITWIN_STATS_EN
    , input bits_consumed, words_in
`endif
  );

  modport slave (
    input  in_data, in_valid, in_last, shift_req, shift_amt, align_req,
    output in_ready, win, win_valid, win_bits, err, eos
`ifdef MPEG_BITWIN_STATS_EN
    , output bits_consumed, words_in
`endif
  );
endinterface

// File: rtl/mpeg_bit_window_merge.sv
// bitwin_merge: next-state value of the 64-bit left-justified bit buffer.
// The buffer is shifted left by the consumed amount and, when a word is loaded,
// the word is OR-ed in directly behind the remaining (post-shift) bits.
//   buf_in    current buffer          shamt     bits consumed this cycle
//   in_data   incoming stream word    count     valid bits before the shift
//   load      a word is accepted      buf_next  resulting buffer
module bitwin_merge
  import mpeg_pkg::*;
(
  input  logic [BUF_W-1:0]   buf_in,
  input  logic [SHIFT_W-1:0] shamt,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [CNT_W-1:0]   count,
  input  logic               load,
  output logic [BUF_W-1:0]   buf_next
);
  logic [CNT_W-1:0] fill_pos_s;
  logic [BUF_W-1:0] shifted_s;
  logic [BUF_W-1:0] word_s;

  // Shift out consumed bits and place a loaded word after the surviving bits.
  always_comb begin
    // A load only happens with count <= 32, so fill_pos_s never exceeds 32.
    fill_pos_s = count - {2'b00, shamt};
    shifted_s  = buf_in << shamt;
    if (load) begin
      word_s = {in_data, 32'd0} >> fill_pos_s;
    end else begin
      word_s = 64'd0;
    end
    buf_next = shifted_s | word_s;
  end
endmodule

// File: rtl/mpeg_bit_window.sv
// mpeg_bit_window: MSB-first bitstream window feeding the VLC decoders.
// Accepts 32-bit words, holds up to 64 bits, exposes the next 20 bits and
// consumes 0..20 bits per cycle; supports byte alignment and end-of-stream drain.
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   mpeg_bit_window_if.slave (stream handshake + decoder window/shift)
// Optional: define MPEG_BITWIN_STATS_EN to add bits_consumed / words_in counters.
module mpeg_bit_window
  import mpeg_pkg::*;
(
  input logic              clk,
  input logic              rst,
  mpeg_bit_window_if.slave bus
);
  state_t             state_r, state_s;
  logic [BUF_W-1:0]   buf_r, buf_next_s;
  logic [CNT_W-1:0]   count_r, count_next_s;
  logic [2:0]         phase_r;
  logic [2:0]         align_amt_s;
  logic               err_r;
  logic [SHIFT_W-1:0] win_bits_s;
  logic [SHIFT_W-1:0] s_amt_s;
  logic               ready_s;
  logic               win_valid_s;
  logic               eos_s;
  logic               shift_ok_s;
  logic               align_ok_s;
  logic               err_set_s;
  logic               accept_s;

  // FSM next state, handshake/window qualifiers and the consumed amount.
  always_comb begin
    state_s     = state_r;
    ready_s     = 1'b0;
    win_valid_s = 1'b0;
    eos_s       = 1'b0;
    win_bits_s  = sat_win_bits(count_r);

    case (state_r)
      S_STREAM: begin
        ready_s     = (count_r <= 7'd32);
        win_valid_s = (count_r >= 7'd20);
      end
      S_DRAIN: begin
        win_valid_s = (count_r != 7'd0);
      end
      S_DONE: begin
        eos_s = 1'b1;
      end
      default: begin
        eos_s = 1'b0;
      end
    endcase

    // win_bits_s never exceeds 20, so this also rejects amounts above 20.
    shift_ok_s  = bus.shift_req && win_valid_s && (bus.shift_amt <= win_bits_s);
    err_set_s   = bus.shift_req && !shift_ok_s;
    // Bits to the next byte boundary: (8 - phase) mod 8.
    align_amt_s = 3'd0 - phase_r;
    // An alignment short of bits is simply retried while align_req stays high.
    align_ok_s  = bus.align_req && !bus.shift_req && ({4'd0, align_amt_s} <= count_r);

    if (shift_ok_s) begin
      s_amt_s = bus.shift_amt;
    end else if (align_ok_s) begin
      s_amt_s = {2'b00, align_amt_s};
    end else begin
      s_amt_s = 5'd0;
    end

    // Readiness is judged on the pre-shift count, so the sum stays <= 64.
    accept_s     = bus.in_valid && ready_s;
    count_next_s = count_r - {2'b00, s_amt_s} + (accept_s ? 7'd32 : 7'd0);

    case (state_r)
      S_STREAM: begin
        if (accept_s && bus.in_last) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (count_next_s == 7'd0) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_s = S_DONE;
      end
      default: begin
        state_s = S_STREAM;
      end
    endcase
  end

  bitwin_merge u_merge (
    .buf_in   (buf_r),
    .shamt    (s_amt_s),
    .in_data  (bus.in_data),
    .count    (count_r),
    .load     (accept_s),
    .buf_next (buf_next_s)
  );

  // State, buffer, count, byte phase and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_STREAM;
      buf_r   <= 64'd0;
      count_r <= 7'd0;
      phase_r <= 3'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_next_s;
      count_r <= count_next_s;
      phase_r <= phase_r + s_amt_s[2:0];
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // in_ready is forced low while reset is held, even though count reads 0.
  assign bus.in_ready  = rst && ready_s;
  assign bus.win       = buf_r[BUF_W-1 -: WIN_W];
  assign bus.win_valid = win_valid_s;
  assign bus.win_bits  = win_bits_s;
  assign bus.err       = err_r;
  assign bus.eos       = eos_s;

`ifdef MPEG_BITWIN_STATS_EN
  logic [31:0] bits_consumed_r;
  logic [15:0] words_in_r;

  // Consumed-bit counter (wrapping) and accepted-word counter (saturating).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_consumed_r <= 32'd0;
      words_in_r      <= 16'd0;
    end else begin
      bits_consumed_r <= bits_consumed_r + {27'd0, s_amt_s};
      if (accept_s && (words_in_r != 16'hFFFF)) begin
        words_in_r <= words_in_r + 16'd1;
      end
    end
  end

  assign bus.bits_consumed = bits_consumed_r;
  assign bus.words_in      = words_in_r;
`endif
endmodule

// File: doc/mpeg_bit_window.md
Name: mpeg_bit_window

Overview:
- MSB-first bitstream window ahead of the VLC decoders (motion code, MB type, CBP).
- Accepts 32-bit stream words through a valid/ready handshake and holds up to 64 bits.
- Presents the next 20 bits as a peek window; consumes 0..20 bits per cycle on the decoder's shift request.
- Also provides byte alignment for start-code search and end-of-stream draining.

Parameters:
- WORD_W, 32, input word width; fixed at 32 in this block.
- WIN_W, 20, peek window width; must be at most WORD_W.
- SHIFT_W, 5, width of the shift amount.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  32  stream word; bit 31 is the earliest bit.
- in_valid  in  1  in_data and in_last are valid.
- in_last  in  1  this word is the final word of the stream.
- in_ready  out  1  the block accepts the word this cycle.
- win  out  20  next 20 stream bits; win[19] is the earliest bit.
- win_valid  out  1  win holds real stream bits (see DRAIN).
- win_bits  out  5  number of real bits in win, saturated at 20.
- shift_req  in  1  consume shift_amt bits.
- shift_amt  in  5  number of bits to consume, 0..20.
- align_req  in  1  discard bits up to the next byte boundary.
- err  out  1  sticky illegal-shift flag.
- eos  out  1  stream fully consumed.

Behaviour:
- Storage: 64-bit register buf plus a 7-bit count (0..64) and a 3-bit byte phase (total bits consumed, mod 8). Valid bits are left-justified in buf; bits below count are zero.
- win = buf[63:44], driven combinationally from registers. win_bits = min(count, 20).
- States: STREAM, DRAIN, DONE. Reset state is STREAM.
- Reset values: buf=0, count=0, phase=0, err=0, in_ready=0 during reset, eos=0.
- STREAM:
  - in_ready = (count <= 32).
  - win_valid = (count >= 20).
  - A word accepted in cycle N is placed at bit position 63-(count-s) and is visible in win at N+1. Here s is the number of bits consumed in the same cycle.
  - An accepted word with in_last=1 moves the block to DRAIN.
- DRAIN:
  - in_ready = 0.
  - win_valid = (count > 0). Missing bits read as 0.
  - The move to DONE happens at the clock edge where the count update produces 0.
- DONE:
  - win_valid = 0, in_ready = 0, eos = 1.
  - Held until reset.
- Shift legality: a shift is legal when shift_req=1, win_valid=1 and shift_amt <= min(win_bits, 20).
  - Legal shift: buf <<= shift_amt, count -= shift_amt, phase += shift_amt.
  - Illegal shift (shift_amt > 20, shift_amt > count, or win_valid=0): shift is ignored and err is set, sticky until reset.
  - shift_amt = 0 is legal and has no effect.
- Alignment: align_req=1 with shift_req=0 discards (8 - phase) mod 8 bits.
  - Legal only if count covers that amount. Otherwise the request is held off with no error: the block retries on each cycle while align_req stays high.
  - align_req and shift_req both high: shift_req wins, align_req is ignored, err is not set.
- Simultaneous shift and refill in one cycle: count_next = count - s + 32. The word lands after the shifted data. Checking in_ready against count before the shift keeps the count at 64 or below.
- Reset mid-operation clears all state immediately, asynchronously. The first word after reset is accepted in the first cycle with rst high and in_valid=1.
- No combinational path from shift_req or shift_amt to in_ready.

Optional Feature:
- Macro: MPEG_BITWIN_STATS_EN.
- When defined:
  - Adds output bits_consumed [31:0]: reset to 0, incremented by every legal shift and alignment amount, wrapping modulo 2^32.
  - Adds output words_in [15:0]: count of accepted words, saturating at 16'hFFFF.
- When undefined: neither port nor the counters exist; the rest of the behaviour is identical.

Decomposition:
- Package mpeg_pkg holds:
  - the WORD_W, WIN_W and SHIFT_W constants;
  - the state encoding localparams ST_STREAM=0, ST_DRAIN=1, ST_DONE=2;
  - localparam VLC_ERROR=17, shared with the VLC decoders.
- One sub-module, bitwin_merge: combinational logic that computes buf_next from buf, the shift amount, in_data and count. The top level keeps the FSM, count, phase, err and handshake logic.

Test Plan:
- Startup: after reset, send words 32'hA5A5_0F0F then 32'h1234_5678 back-to-back.
  - Cycle after the first accept: win=20'hA5A50, win_valid=1, win_bits=20.
  - in_ready drops to 0 after the second word (count=64).
- Steady stream: shift 3 bits every cycle with words continuously available. win follows the concatenated stream bit-exactly versus a reference model, with no bubbles once count >= 20.
- Simultaneous shift and refill: count=30, shift 20, word accepted in the same cycle. Next count = 42, and win starts at old bit 20.
- Alignment: after 13 bits consumed (phase=5), pulse align_req. Exactly 3 bits are discarded and the next win begins at a byte boundary.
- End of stream: last word accepted with in_last=1, then shift until empty.
  - DRAIN shows win_bits < 20 with zero-padded win.
  - eos rises once count reaches 0.
  - A shift of 21, or of 5 when only 3 bits remain, sets err and leaves count unchanged.
- Reset: assert rst mid-stream with count=40. All outputs return to reset values asynchronously, with no stale bits after release.
